// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: shares the register file's single write port between req0 (ALU) and req1 (load).
// Define RR_ARB_EN for round-robin; otherwise fixed priority (req1 first) with a req0 starvation guard.
module regfile_wb_arbiter #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
`ifndef RR_ARB_EN
  ,
  parameter int STARVE_LIMIT = 4
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_rd,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_rd,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              Wen,
  output logic [ADDR_W-1:0] Rd_addr,
  output logic [DATA_W-1:0] write_data,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t            state_r;
  state_t            next_state_s;
  logic              wen_r;
  logic [ADDR_W-1:0] rd_addr_r;
  logic [DATA_W-1:0] write_data_r;
  logic              arb_s;
  logic              tie_pick0_s;
  logic              grant0_s;
  logic              grant1_s;
  logic [ADDR_W-1:0] sel_rd_s;
  logic [DATA_W-1:0] sel_data_s;
  logic              do_write_s;

  assign arb_s = (state_r != WRITE);

`ifdef RR_ARB_EN
  // rr_ptr_r holds the last granted requester; a tie goes to the other one.
  logic rr_ptr_r;

  assign tie_pick0_s = rr_ptr_r;

  // Round-robin pointer, updated on every grant including rd==0 consumes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_r <= 1'b0;
    end else if (grant0_s || grant1_s) begin
      rr_ptr_r <= grant1_s;
    end
  end
`else
  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_r;

  assign tie_pick0_s = (starve_cnt_r == CNT_MAX);

  // Count arbitration cycles req0 waits while valid; saturates, clears when req0 wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else if (grant0_s) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else if (arb_s && req0_valid && (starve_cnt_r != CNT_MAX)) begin
      starve_cnt_r <= starve_cnt_r + CNT_W'(1);
    end
  end
`endif

  // Grant selection; nothing is granted in WRITE or while reset is held.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (arb_s && !reset) begin
      if (req0_valid && req1_valid) begin
        grant0_s = tie_pick0_s;
        grant1_s = !tie_pick0_s;
      end else begin
        grant0_s = req0_valid;
        grant1_s = req1_valid;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  assign sel_rd_s   = grant1_s ? req1_rd : req0_rd;
  assign sel_data_s = grant1_s ? req1_data : req0_data;
  // Writes to register 0 are consumed without touching the register file.
  assign do_write_s = (grant0_s || grant1_s) && (sel_rd_s != {ADDR_W{1'b0}});

  // Next-state logic: every write is one WRITE cycle then one GAP cycle.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE, GAP: begin
        if (do_write_s) begin
          next_state_s = WRITE;
        end else begin
          next_state_s = IDLE;
        end
      end
      WRITE:   next_state_s = GAP;
      default: next_state_s = IDLE;
    endcase
  end

  // State and registered write-port outputs; address/data only load on entry to WRITE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      wen_r        <= 1'b0;
      rd_addr_r    <= {ADDR_W{1'b0}};
      write_data_r <= {DATA_W{1'b0}};
    end else begin
      state_r <= next_state_s;
      wen_r   <= do_write_s;
      if (do_write_s) begin
        rd_addr_r    <= sel_rd_s;
        write_data_r <= sel_data_s;
      end
    end
  end

  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;
  assign Wen        = wen_r;
  assign Rd_addr    = rd_addr_r;
  assign write_data = write_data_r;
  assign busy       = (state_r == WRITE);

endmodule
